// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified memory between instruction
// fetch and data (LW/SW) accesses. Fixed priority write > read > fetch, one
// access at a time, MEM_LAT cycles per access, then a one-cycle ready pulse.
module mem_arbiter #(
   parameter int MEM_LAT = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rdy,
   output logic [DATA_W-1:0] if_data,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_rdy,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_re,
   output logic              m_we,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   // Counter wide enough for the largest legal latency (15).
   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DREAD,
      S_DWRITE,
      S_RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             serve_fetch;  // owner of the current access / ready pulse
   logic             access_done;

   assign access_done = (cnt == CNT_LAST);

   // Stalls follow the requests directly so IF/MEM freeze in the request cycle.
   assign stall_if  = if_req & ~if_rdy;
   assign stall_mem = (d_rd | d_wr) & ~d_rdy;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: fixed-priority grant in IDLE, fixed-length access.
   always_comb begin
      // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (d_wr)        state_nxt = S_DWRITE;
            else if (d_rd)   state_nxt = S_DREAD;
            else if (if_req) state_nxt = S_FETCH;
         end
         S_FETCH, S_DREAD, S_DWRITE: begin
            if (access_done) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: enables during the access, ready pulse in RESP.
   always_comb begin
      m_re   = 1'b0;
      m_we   = 1'b0;
      if_rdy = 1'b0;
      d_rdy  = 1'b0;
      case (state)
         S_FETCH, S_DREAD: m_re = 1'b1;
         S_DWRITE:         m_we = 1'b1;
         S_RESP: begin
            if_rdy = serve_fetch;
            d_rdy  = ~serve_fetch;
         end
         default: ;
      endcase
   end

   // Datapath: latch address/data on grant, count the access, capture read data.
   always_ff @(posedge clk) begin
      // NOTE: the output registers are reset too, since a reset mid-access
      // must leave every externally visible value at zero.
      if (rst) begin
         cnt         <= '0;
         serve_fetch <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         if_data     <= '0;
         d_rdata     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (d_wr) begin
                  m_addr      <= d_addr;
                  m_wdata     <= d_wdata;
                  serve_fetch <= 1'b0;
               end else if (d_rd) begin
                  m_addr      <= d_addr;
                  serve_fetch <= 1'b0;
               end else if (if_req) begin
                  m_addr      <= if_addr;
                  serve_fetch <= 1'b1;
               end
            end
            S_FETCH: begin
               cnt <= cnt + 1'b1;
               if (access_done) if_data <= m_rdata;
            end
            S_DREAD: begin
               cnt <= cnt + 1'b1;
               if (access_done) d_rdata <= m_rdata;
            end
            S_DWRITE: cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a MEM_LAT=4 instance driven by directed and
// randomized transactions, and a MEM_LAT=1 instance for back-to-back fetches.
// Expected timing is computed per transaction from the slot arithmetic
// (each grant occupies MEM_LAT+2 cycles, data before fetch, write before read).
module tb_mem_arbiter;

   localparam int MEM_LAT = 4;
   localparam int SLOT    = MEM_LAT + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_rdy;
   logic [15:0] if_data;
   logic        d_rd = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_rdy;
   logic [15:0] d_rdata;
   logic        stall_if, stall_mem;
   logic [15:0] m_addr;
   logic        m_re, m_we;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;

   // Second instance, MEM_LAT = 1, fetch port only.
   logic        if_req1 = 1'b0;
   logic [15:0] if_addr1 = '0;
   logic        if_rdy1;
   logic [15:0] if_data1;
   logic        d_rdy1;
   logic [15:0] d_rdata1;
   logic        stall_if1, stall_mem1;
   logic [15:0] m_addr1;
   logic        m_re1, m_we1;
   logic [15:0] m_wdata1;
   logic [15:0] m_rdata1;

   mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(16), .DATA_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdy(d_rdy), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdy(if_rdy1), .if_data(if_data1),
      .d_rd(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
      .d_rdy(d_rdy1), .d_rdata(d_rdata1),
      .stall_if(stall_if1), .stall_mem(stall_mem1),
      .m_addr(m_addr1), .m_re(m_re1), .m_we(m_we1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
   );

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return 16'((a * 16'h9E37) ^ 16'h5A5A);
   endfunction

   // Memory macro: read data is only valid in the last cycle of a read access.
   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   int          re_cnt = 0;

   always @(posedge clk) begin
      if (m_we) mem[m_addr] <= m_wdata;
      if (m_re) re_cnt <= re_cnt + 1;
      else      re_cnt <= 0;
   end

   assign m_rdata  = (m_re && re_cnt == MEM_LAT - 1) ? mem[m_addr] : 16'hDEAD;
   assign m_rdata1 = m_re1 ? init_val(m_addr1) : 16'hDEAD;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_if_data = '0;
   logic [15:0] exp_d_rdata = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Quiet cycles with no requests: nothing may move.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle m_re", m_re, 0);
         check("idle m_we", m_we, 0);
         check("idle if_rdy", if_rdy, 0);
         check("idle d_rdy", d_rdy, 0);
         check("idle stall_if", stall_if, 0);
         check("idle stall_mem", stall_mem, 0);
         check("idle if_data", if_data, exp_if_data);
         check("idle d_rdata", d_rdata, exp_d_rdata);
         @(posedge clk); #1;
      end
   endtask

   // Raise the requested set in one IDLE cycle and check every cycle until all
   // are served. Slot 0 goes to the data port if present, fetch takes the last.
   task automatic run_txn(input bit do_f, input logic [15:0] fa,
                          input bit do_rd, input bit do_wr,
                          input logic [15:0] da, input logic [15:0] dw,
                          input bit early_drop);
      bit has_d, d_turn, acc, resp, e_re, e_we, e_if, e_d;
      int nslots, slot, ph;
      has_d  = do_rd | do_wr;
      nslots = int'(do_f) + int'(has_d);
      if_req = do_f;  if_addr = fa;
      d_rd = do_rd; d_wr = do_wr; d_addr = da; d_wdata = dw;
      for (int c = 0; c < nslots * SLOT; c++) begin
         slot   = c / SLOT;
         ph     = c % SLOT;
         d_turn = has_d && slot == 0;
         acc    = ph >= 1 && ph <= MEM_LAT;
         resp   = ph == MEM_LAT + 1;
         e_re   = acc && !(d_turn && do_wr);
         e_we   = acc && d_turn && do_wr;
         e_if   = resp && !d_turn;
         e_d    = resp && d_turn;
         if (e_if) exp_if_data = ref_mem[fa];
         if (e_d && !do_wr) exp_d_rdata = ref_mem[da];
         @(negedge clk);
         check("m_re", m_re, e_re);
         check("m_we", m_we, e_we);
         check("if_rdy", if_rdy, e_if);
         check("d_rdy", d_rdy, e_d);
         check("stall_if", stall_if, if_req & ~e_if);
         check("stall_mem", stall_mem, (d_rd | d_wr) & ~e_d);
         check("if_data", if_data, exp_if_data);
         check("d_rdata", d_rdata, exp_d_rdata);
         if (acc) check("m_addr", m_addr, d_turn ? da : fa);
         if (e_we) check("m_wdata", m_wdata, dw);
         @(posedge clk); #1;
         if (e_d && do_wr) ref_mem[da] = dw;
         if (e_if) if_req = 1'b0;
         if (e_d) begin d_rd = 1'b0; d_wr = 1'b0; end
         if (early_drop && nslots == 1 && ph == 2) begin
            if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
         end
      end
   endtask

   initial begin
      bit          f, rd, wr;
      logic [15:0] exp_if1;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = init_val(16'(i));
         ref_mem[i] = init_val(16'(i));
      end
      mem[16'h0010] = 16'hB123; ref_mem[16'h0010] = 16'hB123;
      mem[16'h8000] = 16'h00FF; ref_mem[16'h8000] = 16'h00FF;

      // Reset state, both instances.
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst m_re", m_re, 0);
      check("rst m_we", m_we, 0);
      check("rst if_rdy", if_rdy, 0);
      check("rst d_rdy", d_rdy, 0);
      check("rst m_addr", m_addr, 0);
      check("rst m_wdata", m_wdata, 0);
      check("rst if_data", if_data, 0);
      check("rst d_rdata", d_rdata, 0);
      check("rst stall_if", stall_if, 0);
      check("rst stall_mem", stall_mem, 0);
      check("rst1 m_re", m_re1, 0);
      check("rst1 if_data", if_data1, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycles(2);

      // Single fetch, then data-vs-fetch contention.
      run_txn(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0);
      idle_cycles(1);
      run_txn(1, 16'h0020, 1, 0, 16'h8000, 16'h0000, 0);

      // Store, read-back, and write+read collision.
      run_txn(0, 16'h0000, 0, 1, 16'h4000, 16'hA5A5, 0);
      run_txn(0, 16'h0000, 1, 0, 16'h4000, 16'h0000, 0);
      run_txn(0, 16'h0000, 1, 1, 16'h4002, 16'h1234, 0);
      run_txn(1, 16'h0031, 1, 0, 16'h4002, 16'h0000, 0);

      // Requests withdrawn mid-access still complete.
      run_txn(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1);
      run_txn(0, 16'h0000, 0, 1, 16'h4003, 16'h0F0F, 1);
      run_txn(0, 16'h0000, 1, 0, 16'h4003, 16'h0000, 1);

      // Reset in the second fetch cycle abandons the access.
      if_req = 1'b1; if_addr = 16'h0123;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("pre-rst m_re", m_re, 1);
      @(posedge clk); #1;
      rst = 1'b0; if_req = 1'b0;
      exp_if_data = '0; exp_d_rdata = '0;
      @(negedge clk);
      check("post-rst m_re", m_re, 0);
      check("post-rst if_rdy", if_rdy, 0);
      check("post-rst m_addr", m_addr, 0);
      check("post-rst m_wdata", m_wdata, 0);
      check("post-rst if_data", if_data, 0);
      check("post-rst d_rdata", d_rdata, 0);
      @(posedge clk); #1;
      idle_cycles(SLOT);
      run_txn(1, 16'h0123, 0, 0, 16'h0000, 16'h0000, 0);

      // Randomized transaction mix.
      for (int t = 0; t < 60; t++) begin
         f  = 1'($urandom);
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!f && !rd && !wr) f = 1'b1;
         run_txn(f, 16'($urandom), rd, wr, 16'h4000 | 16'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 3) == 0));
         idle_cycles($urandom_range(0, 2));
      end

      // MEM_LAT=1 back-to-back fetches with if_req held high.
      exp_if1  = '0;
      if_req1  = 1'b1;
      if_addr1 = 16'($urandom);
      for (int c = 0; c < 30; c++) begin
         if (c % 3 == 2) exp_if1 = init_val(if_addr1);
         @(negedge clk);
         check("l1 if_rdy", if_rdy1, (c % 3 == 2));
         check("l1 m_re", m_re1, (c % 3 == 1));
         check("l1 stall_if", stall_if1, (c % 3 != 2));
         check("l1 if_data", if_data1, exp_if1);
         if (c % 3 == 1) check("l1 m_addr", m_addr1, if_addr1);
         @(posedge clk); #1;
         if (c % 3 == 2) if_addr1 = 16'($urandom);
      end
      if_req1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
